// File: rtl/iterative_multiplier_if.sv
// Operand/result bundle between the register-file read/write ports and the iterative multiplier.
// The master drives the request fields and the slave (the multiplier) drives status and write-back.
interface iterative_multiplier_if #(
    parameter int WIDTH  = 64,
    parameter int ADDR_W = 5
);
    logic              Start;
    logic              Flush;
    logic              Hi;
    logic [WIDTH-1:0]  BusA;
    logic [WIDTH-1:0]  BusB;
    logic [ADDR_W-1:0] Rd;
    logic              Busy;
    logic [WIDTH-1:0]  BusW;
    logic [ADDR_W-1:0] RW;
    logic              RegWr;

    modport master (
        output Start, Flush, Hi, BusA, BusB, Rd,
        input  Busy, BusW, RW, RegWr
    );

    modport slave (
        input  Start, Flush, Hi, BusA, BusB, Rd,
        output Busy, BusW, RW, RegWr
    );
endinterface

// File: rtl/iterative_multiplier.sv
// Unsigned shift-add multiplier, one multiplier bit per clock; MUL_HIGH_EN adds the UMULH (Hi) path.
// Latency: RegWr pulses WIDTH+1 edges after the accepting edge; fixed, with no early exit.
// Backpressure: Start is taken only in IDLE and never queued; Flush aborts with no write-back.
module iterative_multiplier #(
    parameter int WIDTH  = 64,
    parameter int ADDR_W = 5
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    iterative_multiplier_if.slave bus
);
`ifdef MUL_HIGH_EN
    localparam int ACC_W = 2 * WIDTH;
`else
    localparam int ACC_W = WIDTH;
`endif
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_WB} state_t;

    state_t            r_state;
    logic [ACC_W-1:0]  r_acc;
    logic [ACC_W-1:0]  r_mcand;
    logic [WIDTH-1:0]  r_mplier;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_rd;
    logic              r_busy;
    logic              r_regwr;
    logic [WIDTH-1:0]  r_busw;
    logic [ADDR_W-1:0] r_rw;
    logic [WIDTH-1:0]  w_result;

`ifdef MUL_HIGH_EN
    logic r_hi;
    assign w_result = r_hi ? r_acc[ACC_W-1:WIDTH] : r_acc[WIDTH-1:0];
`else
    logic w_unused_hi;
    assign w_unused_hi = bus.Hi;
    assign w_result    = r_acc;
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state  <= S_IDLE;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_rd     <= '0;
            r_busy   <= 1'b0;
            r_regwr  <= 1'b0;
            r_busw   <= '0;
            r_rw     <= '0;
`ifdef MUL_HIGH_EN
            r_hi     <= 1'b0;
`endif
        end else begin
            r_regwr <= 1'b0;
            // Flush outranks every state, including the WB cycle that would raise RegWr.
            if (bus.Flush) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.Start) begin
                            r_mcand  <= ACC_W'(bus.BusA);
                            r_mplier <= bus.BusB;
                            r_rd     <= bus.Rd;
                            r_acc    <= '0;
                            r_cnt    <= '0;
                            r_busy   <= 1'b1;
                            r_state  <= S_RUN;
`ifdef MUL_HIGH_EN
                            r_hi     <= bus.Hi;
`endif
                        end
                    end
                    S_RUN: begin
                        if (r_mplier[0]) begin
                            r_acc <= r_acc + r_mcand;
                        end
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_cnt    <= r_cnt + 1'b1;
                        if (r_cnt == CNT_W'(WIDTH - 1)) begin
                            r_state <= S_WB;
                        end
                    end
                    S_WB: begin
                        r_busw  <= w_result;
                        r_rw    <= r_rd;
                        r_regwr <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.Busy  = r_busy;
    assign bus.BusW  = r_busw;
    assign bus.RW    = r_rw;
    assign bus.RegWr = r_regwr;
endmodule

// File: tb/tb_iterative_multiplier.sv
// Directed-vector bench for iterative_multiplier: latency, wrap, high half, busy-start, flush, reset.
module tb_iterative_multiplier;
    localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

    logic Clk;
    logic Reset_n;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   t_acc = 0;

    iterative_multiplier_if #(.WIDTH(64), .ADDR_W(5)) mif ();

    iterative_multiplier #(.WIDTH(64), .ADDR_W(5)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (mif.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic start_op(input logic [63:0] a, input logic [63:0] b,
                            input logic [4:0] rd, input logic hi);
        @(negedge Clk);
        mif.Start = 1'b1;
        mif.BusA  = a;
        mif.BusB  = b;
        mif.Rd    = rd;
        mif.Hi    = hi;
        @(negedge Clk);
        mif.Start = 1'b0;
        t_acc     = cyc;
    endtask

    // Polls at negedges until RegWr rises; lat = edges since accept, -1 on timeout.
    task automatic wait_wr(output int lat, output int busy_low);
        lat      = -1;
        busy_low = 0;
        for (int i = 0; i < 200; i++) begin
            if (mif.RegWr) begin
                lat = cyc - t_acc;
                break;
            end
            if (!mif.Busy) busy_low++;
            @(negedge Clk);
        end
    endtask

    task automatic count_wr(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            if (mif.RegWr) pulses++;
        end
    endtask

    task automatic test_reset;
        Reset_n = 1'b0;
        repeat (2) @(negedge Clk);
        n_vec++;
        if (mif.Busy !== 1'b0 || mif.RegWr !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: Busy=%b RegWr=%b want 0 0", mif.Busy, mif.RegWr);
        end
        n_vec++;
        if (mif.BusW !== 64'd0 || mif.RW !== 5'd0) begin
            n_err++;
            $display("FAIL reset_bus: BusW=%h RW=%0d want 0 0", mif.BusW, mif.RW);
        end
        Reset_n = 1'b1;
        @(negedge Clk);
        n_vec++;
        if (mif.Busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release_busy: got %b want 0", mif.Busy);
        end
    endtask

    task automatic test_basic;
        int lat, bl;
        start_op(64'd3, 64'd5, 5'd4, 1'b0);
        wait_wr(lat, bl);
        n_vec++;
        if (lat !== 65) begin
            n_err++;
            $display("FAIL basic_latency: got %0d want 65", lat);
        end
        n_vec++;
        if (bl !== 0) begin
            n_err++;
            $display("FAIL basic_busy: Busy low for %0d cycles want 0", bl);
        end
        n_vec++;
        if (mif.BusW !== 64'd15 || mif.RW !== 5'd4) begin
            n_err++;
            $display("FAIL basic_result: BusW=%0d RW=%0d want 15 4", mif.BusW, mif.RW);
        end
        @(negedge Clk);
        n_vec++;
        if (mif.RegWr !== 1'b0 || mif.BusW !== 64'd15 || mif.RW !== 5'd4) begin
            n_err++;
            $display("FAIL basic_hold: RegWr=%b BusW=%0d RW=%0d want 0 15 4", mif.RegWr, mif.BusW, mif.RW);
        end
    endtask

    task automatic test_wrap;
        int lat, bl;
        start_op(ALL1, 64'd2, 5'd7, 1'b0);
        wait_wr(lat, bl);
        n_vec++;
        if (lat !== 65 || mif.BusW !== 64'hFFFF_FFFF_FFFF_FFFE || mif.RW !== 5'd7) begin
            n_err++;
            $display("FAIL wrap: lat=%0d BusW=%h RW=%0d want 65 fffffffffffffffe 7", lat, mif.BusW, mif.RW);
        end
        start_op(64'd0, ALL1, 5'd3, 1'b0);
        wait_wr(lat, bl);
        n_vec++;
        if (lat !== 65 || mif.BusW !== 64'd0 || mif.RW !== 5'd3) begin
            n_err++;
            $display("FAIL zero_operand: lat=%0d BusW=%h RW=%0d want 65 0 3", lat, mif.BusW, mif.RW);
        end
    endtask

    task automatic test_high;
        int lat, bl;
        logic [63:0] exp_hi;
`ifdef MUL_HIGH_EN
        exp_hi = 64'hFFFF_FFFF_FFFF_FFFE;
`else
        exp_hi = 64'd1;
`endif
        start_op(ALL1, ALL1, 5'd10, 1'b1);
        wait_wr(lat, bl);
        n_vec++;
        if (lat !== 65 || mif.BusW !== exp_hi || mif.RW !== 5'd10) begin
            n_err++;
            $display("FAIL high_sel: lat=%0d BusW=%h RW=%0d want 65 %h 10", lat, mif.BusW, mif.RW, exp_hi);
        end
        start_op(ALL1, ALL1, 5'd11, 1'b0);
        wait_wr(lat, bl);
        n_vec++;
        if (lat !== 65 || mif.BusW !== 64'd1 || mif.RW !== 5'd11) begin
            n_err++;
            $display("FAIL low_sel: lat=%0d BusW=%h RW=%0d want 65 1 11", lat, mif.BusW, mif.RW);
        end
    endtask

    task automatic test_back_to_back;
        int lat, bl;
        start_op(64'd6, 64'd9, 5'd2, 1'b0);
        repeat (9) @(negedge Clk);
        mif.Start = 1'b1;
        mif.BusA  = 64'd7;
        mif.BusB  = 64'd7;
        mif.Rd    = 5'd9;
        @(negedge Clk);
        mif.Start = 1'b0;
        wait_wr(lat, bl);
        n_vec++;
        if (lat !== 65 || mif.BusW !== 64'd54 || mif.RW !== 5'd2) begin
            n_err++;
            $display("FAIL busy_start_ignored: lat=%0d BusW=%0d RW=%0d want 65 54 2", lat, mif.BusW, mif.RW);
        end
        mif.Start = 1'b1;
        @(negedge Clk);
        mif.Start = 1'b0;
        t_acc     = cyc;
        n_vec++;
        if (mif.Busy !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_accept: Busy=%b want 1", mif.Busy);
        end
        wait_wr(lat, bl);
        n_vec++;
        if (lat !== 65 || mif.BusW !== 64'd49 || mif.RW !== 5'd9) begin
            n_err++;
            $display("FAIL b2b_result: lat=%0d BusW=%0d RW=%0d want 65 49 9", lat, mif.BusW, mif.RW);
        end
    endtask

    task automatic test_flush;
        int pulses;
        start_op(64'd11, 64'd13, 5'd5, 1'b0);
        repeat (29) @(negedge Clk);
        mif.Flush = 1'b1;
        @(negedge Clk);
        mif.Flush = 1'b0;
        n_vec++;
        if (mif.Busy !== 1'b0) begin
            n_err++;
            $display("FAIL flush_run_busy: got %b want 0", mif.Busy);
        end
        count_wr(100, pulses);
        n_vec++;
        if (pulses !== 0) begin
            n_err++;
            $display("FAIL flush_run_nowrite: got %0d pulses want 0", pulses);
        end
        @(negedge Clk);
        mif.Start = 1'b1;
        mif.Flush = 1'b1;
        @(negedge Clk);
        mif.Start = 1'b0;
        mif.Flush = 1'b0;
        n_vec++;
        if (mif.Busy !== 1'b0) begin
            n_err++;
            $display("FAIL flush_start_busy: got %b want 0", mif.Busy);
        end
        count_wr(70, pulses);
        n_vec++;
        if (pulses !== 0) begin
            n_err++;
            $display("FAIL flush_start_nowrite: got %0d pulses want 0", pulses);
        end
        start_op(64'd2, 64'd3, 5'd6, 1'b0);
        repeat (64) @(negedge Clk);
        n_vec++;
        if (mif.Busy !== 1'b1 || mif.RegWr !== 1'b0) begin
            n_err++;
            $display("FAIL wb_state: Busy=%b RegWr=%b want 1 0", mif.Busy, mif.RegWr);
        end
        mif.Flush = 1'b1;
        @(negedge Clk);
        mif.Flush = 1'b0;
        n_vec++;
        if (mif.RegWr !== 1'b0 || mif.Busy !== 1'b0) begin
            n_err++;
            $display("FAIL flush_wb: RegWr=%b Busy=%b want 0 0", mif.RegWr, mif.Busy);
        end
        count_wr(70, pulses);
        n_vec++;
        if (pulses !== 0) begin
            n_err++;
            $display("FAIL flush_wb_nowrite: got %0d pulses want 0", pulses);
        end
    endtask

    task automatic test_reset_mid;
        int pulses, lat, bl;
        start_op(64'd5, 64'd5, 5'd8, 1'b0);
        repeat (39) @(negedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        n_vec++;
        if (mif.Busy !== 1'b0 || mif.RegWr !== 1'b0 || mif.BusW !== 64'd0 || mif.RW !== 5'd0) begin
            n_err++;
            $display("FAIL reset_mid: Busy=%b RegWr=%b BusW=%h RW=%0d want 0 0 0 0",
                     mif.Busy, mif.RegWr, mif.BusW, mif.RW);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        count_wr(100, pulses);
        n_vec++;
        if (pulses !== 0) begin
            n_err++;
            $display("FAIL reset_mid_nowrite: got %0d pulses want 0", pulses);
        end
        start_op(64'd1000, 64'd1000, 5'd31, 1'b0);
        wait_wr(lat, bl);
        n_vec++;
        if (lat !== 65 || mif.BusW !== 64'd1000000 || mif.RW !== 5'd31) begin
            n_err++;
            $display("FAIL rd31: lat=%0d BusW=%0d RW=%0d want 65 1000000 31", lat, mif.BusW, mif.RW);
        end
    endtask

    initial begin
        Reset_n   = 1'b0;
        mif.Start = 1'b0;
        mif.Flush = 1'b0;
        mif.Hi    = 1'b0;
        mif.BusA  = '0;
        mif.BusB  = '0;
        mif.Rd    = '0;
        test_reset();
        test_basic();
        test_wrap();
        test_high();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
